spi_cmd_sequencer: RTL

Command sequencer on the 64-bit SPI word interface. It watches the word-complete flag from the SPI word wrapper and decodes each received word as a command header or payload. It runs multi-word register write and read bursts against the core register file, and loads the next outgoing word (read data or status) for the full-duplex response. It sits between the SPI word wrapper and the register file and is that wrapper's only client.

---
 rtl/spi_cmd_sequencer.sv | 120 ++++++++++++
 1 files changed

// File: rtl/spi_cmd_sequencer.sv
// spi_cmd_sequencer: decodes SPI command words into register write/read bursts and stages the response word.
module spi_cmd_sequencer #(
    parameter logic [7:0] MAGIC = 8'hA5,
    parameter int MAX_BURST = 16
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        word_received,
    input  logic [63:0] word_data_received,
    input  logic        cs_active,
    output logic [63:0] word_send_data,
    output logic [7:0]  reg_addr,
    output logic [63:0] reg_wdata,
    output logic        reg_wr_en,
    output logic        reg_rd_en,
    input  logic [63:0] reg_rdata,
    output logic        busy,
    output logic        err_opcode,
    output logic        err_abort
);
    typedef enum logic [2:0] {IDLE, WR_DATA, RD_FETCH, RD_LOAD, RD_XFER, ST_LOAD} state_t;
    localparam logic [7:0] MAXB = 8'(MAX_BURST);
    state_t state;
    logic word_received_s, word_received_q, wpulse;
    logic [7:0] last_op, hdr_op, hdr_addr, hdr_n;
    logic [4:0] cnt, n_clamp;
    assign wpulse = word_received_s & ~word_received_q;
    assign hdr_op = word_data_received[7:0];
    assign hdr_addr = word_data_received[15:8];
    assign hdr_n = word_data_received[23:16];
    assign n_clamp = hdr_n > MAXB ? MAXB[4:0] : hdr_n[4:0];
    function automatic logic [63:0] status(input logic eo, input logic ea, input logic [7:0] op);
        return {40'd0, op, 6'd0, ea, eo, MAGIC};
    endfunction
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state <= IDLE;
            word_received_s <= 1'b0;
            word_received_q <= 1'b0;
            word_send_data <= status(1'b0, 1'b0, 8'd0);
            reg_addr <= 8'd0;
            reg_wdata <= 64'd0;
            reg_wr_en <= 1'b0;
            reg_rd_en <= 1'b0;
            busy <= 1'b0;
            err_opcode <= 1'b0;
            err_abort <= 1'b0;
            last_op <= 8'd0;
            cnt <= 5'd0;
        end else begin
            word_received_s <= word_received;
            word_received_q <= word_received_s;
            reg_wr_en <= 1'b0;
            reg_rd_en <= 1'b0;
            // the address advances the cycle after a write so it stays valid alongside the strobe
            if (reg_wr_en) reg_addr <= reg_addr + 8'd1;
            if (state != IDLE && !cs_active) begin
                state <= IDLE;
                busy <= 1'b0;
                err_abort <= 1'b1;
                word_send_data <= status(err_opcode, 1'b1, last_op);
            end else begin
                case (state)
                    IDLE: if (wpulse) begin
                        last_op <= hdr_op;
                        busy <= 1'b1;
                        if (hdr_op == 8'h01 && n_clamp != 5'd0) begin
                            state <= WR_DATA;
                            reg_addr <= hdr_addr;
                            cnt <= n_clamp;
                        end else if (hdr_op == 8'h02 && n_clamp != 5'd0) begin
                            state <= RD_FETCH;
                            reg_addr <= hdr_addr;
                            cnt <= n_clamp;
                            reg_rd_en <= 1'b1;
                        end else begin
                            state <= ST_LOAD;
                            if (hdr_op == 8'h04) begin
                                err_opcode <= 1'b0;
                                err_abort <= 1'b0;
                            end
                            if (hdr_op > 8'h04) err_opcode <= 1'b1;
                        end
                    end
                    WR_DATA: if (wpulse) begin
                        reg_wr_en <= 1'b1;
                        reg_wdata <= word_data_received;
                        cnt <= cnt - 5'd1;
                        if (cnt == 5'd1) begin
                            state <= IDLE;
                            busy <= 1'b0;
                        end
                    end
                    RD_FETCH: state <= RD_LOAD;
                    RD_LOAD: begin
                        word_send_data <= reg_rdata;
                        reg_addr <= reg_addr + 8'd1;
                        state <= RD_XFER;
                    end
                    RD_XFER: if (wpulse) begin
                        cnt <= cnt - 5'd1;
                        if (cnt == 5'd1) begin
                            state <= IDLE;
                            busy <= 1'b0;
                            word_send_data <= status(err_opcode, err_abort, last_op);
                        end else begin
                            state <= RD_FETCH;
                            reg_rd_en <= 1'b1;
                        end
                    end
                    default: begin
                        word_send_data <= status(err_opcode, err_abort, last_op);
                        state <= IDLE;
                        busy <= 1'b0;
                    end
                endcase
            end
        end
    end
endmodule
